// File: rtl/ascii_display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : ascii_display_scanner_if
// Brief    : Character-load stream (valid/ready/data) plus buffer clear.
// Revision : 1.0 - initial release
// ============================================================================
interface ascii_display_scanner_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       clear;

    modport master (output char_valid, output char_data, output clear, input  char_ready);
    modport slave  (input  char_valid, input  char_data, input  clear, output char_ready);
endinterface
`default_nettype wire

// File: rtl/ascii_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : ascii_display_scanner
// Brief    : Character buffer + time-multiplexed scan for a shared ASCII->7seg
//            decoder. Define ASCII_SCAN_HEX_EN to also keep hex letters A-F/a-f.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_display_scanner #(
    parameter int         NUM_DIGITS  = 4,
    parameter int         REFRESH_DIV = 1000,
    parameter logic [7:0] BLANK_CODE  = 8'h20
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    ascii_display_scanner_if.slave             char_if,
    output logic [7:0]                         ascii_code,
    output logic [NUM_DIGITS-1:0]              digit_en,
    output logic [$clog2(NUM_DIGITS)-1:0]      scan_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        S_GUARD = 1'b0,
        S_ON    = 1'b1
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        scan_idx_q;
    logic [NUM_DIGITS-1:0]   digit_en_q;
    logic [7:0]              ascii_code_q;
    logic [7:0]              char_buf_q [NUM_DIGITS];
    logic [7:0]              char_buf_d [NUM_DIGITS];
    logic                    run_q;
    logic                    run_d;
    logic                    char_ready;
    logic [IDX_W-1:0]        next_idx;
    logic [NUM_DIGITS-1:0]   next_en;

    function automatic logic [7:0] filter_char(input logic [7:0] c);
        logic [7:0] r;
        r = BLANK_CODE;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = c;
        end
`ifdef ASCII_SCAN_HEX_EN
        else if (c >= 8'h41 && c <= 8'h46) begin
            r = c;
        end
        else if (c >= 8'h61 && c <= 8'h66) begin
            r = c - 8'h20;
        end
`endif
        return r;
    endfunction

    // run_q marks the first edge after reset release; ready is held low until then.
    assign run_d           = 1'b1;
    assign char_ready      = run_q & ~char_if.clear;
    assign char_if.char_ready = char_ready;

    always_comb begin
        char_buf_d = char_buf_q;
        if (char_if.clear) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                char_buf_d[k] = BLANK_CODE;
            end
        end else if (char_if.char_valid && char_ready) begin
            for (int k = NUM_DIGITS - 1; k > 0; k--) begin
                char_buf_d[k] = char_buf_q[k-1];
            end
            char_buf_d[0] = filter_char(char_if.char_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                char_buf_q[k] <= BLANK_CODE;
            end
        end else begin
            run_q      <= run_d;
            char_buf_q <= char_buf_d;
        end
    end

    assign next_idx = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
    assign next_en  = NUM_DIGITS'(1) << next_idx;

    // GUARD loads enable and code of the upcoming digit together, so the first
    // lit cycle never pairs a new enable with a stale character.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_GUARD;
            cnt_q        <= '0;
            scan_idx_q   <= IDX_LAST;
            digit_en_q   <= '0;
            ascii_code_q <= BLANK_CODE;
        end else begin
            case (state_q)
                S_GUARD: begin
                    scan_idx_q   <= next_idx;
                    cnt_q        <= '0;
                    digit_en_q   <= next_en;
                    ascii_code_q <= char_buf_q[next_idx];
                    state_q      <= S_ON;
                end
                S_ON: begin
                    ascii_code_q <= char_buf_q[scan_idx_q];
                    if (cnt_q == CNT_MAX) begin
                        digit_en_q <= '0;
                        state_q    <= S_GUARD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    digit_en_q <= '0;
                    state_q    <= S_GUARD;
                end
            endcase
        end
    end

    assign ascii_code = ascii_code_q;
    assign digit_en   = digit_en_q;
    assign scan_idx   = scan_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_ascii_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascii_display_scanner
// Brief    : Self-checking bench: timing/buffer model plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascii_display_scanner;

    localparam int N = 4;
    localparam int D = 4;
    localparam int PERIOD = N * (D + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ascii_code;
    logic [N-1:0] digit_en;
    logic [1:0] scan_idx;

    int checks = 0;
    int errors = 0;

    ascii_display_scanner_if u_if ();

    ascii_display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (D),
        .BLANK_CODE  (8'h20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_if    (u_if),
        .ascii_code (ascii_code),
        .digit_en   (digit_en),
        .scan_idx   (scan_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_filter(input logic [7:0] c);
        if (c inside {[8'h30:8'h39]}) return c;
`ifdef ASCII_SCAN_HEX_EN
        if (c inside {[8'h41:8'h46]}) return c;
        if (c inside {[8'h61:8'h66]}) return c - 8'h20;
`endif
        return 8'h20;
    endfunction

    // Model: k = edges since reset release; mbuf = buffer now, mprev = before last edge.
    int         k;
    logic [7:0] mbuf  [N];
    logic [7:0] mprev [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 0;
            for (int i = 0; i < N; i++) begin
                mbuf[i]  <= 8'h20;
                mprev[i] <= 8'h20;
            end
        end else begin
            mprev <= mbuf;
            if (u_if.clear) begin
                for (int i = 0; i < N; i++) mbuf[i] <= 8'h20;
            end else if (u_if.char_valid && k >= 1) begin
                for (int i = 1; i < N; i++) mbuf[i] <= mbuf[i-1];
                mbuf[0] <= ref_filter(u_if.char_data);
            end
            k <= k + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_digit_en", 32'(digit_en), 0);
            chk("rst_ascii", 32'(ascii_code), 32'h20);
            chk("rst_scan_idx", 32'(scan_idx), N - 1);
            chk("rst_ready", 32'(u_if.char_ready), 0);
        end else begin
            int  pos;
            int  dig;
            bit  on;
            pos = (k - 1) % (D + 1);
            dig = ((k - 1) / (D + 1)) % N;
            on  = (k >= 1) && (pos < D);
            chk("m_digit_en", 32'(digit_en), on ? (32'd1 << dig) : 32'd0);
            chk("m_scan_idx", 32'(scan_idx), (k == 0) ? N - 1 : dig);
            chk("m_ready", 32'(u_if.char_ready), 32'((k >= 1) && !u_if.clear));
            if (on) chk("m_ascii", 32'(ascii_code), 32'(mprev[dig]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] c);
        u_if.char_valid = 1'b1;
        u_if.char_data  = c;
        step();
        u_if.char_valid = 1'b0;
        u_if.char_data  = 8'h00;
    endtask

    task automatic wait_digit(input int d, input logic [7:0] exp_code, input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !found; i++) begin
            @(negedge clk);
            if (digit_en == (4'b0001 << d)) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: digit %0d never lit, digit_en %0h", nm, d, digit_en);
        end else begin
            chk(nm, 32'(ascii_code), 32'(exp_code));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_seq [7];
        logic [7:0] hx;
        exp_seq = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
`ifdef ASCII_SCAN_HEX_EN
        hx = 8'h41;
`else
        hx = 8'h20;
`endif
        u_if.char_valid = 1'b0;
        u_if.char_data  = 8'h00;
        u_if.clear      = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("rel_digit_en", 32'(digit_en), 32'(exp_seq[i]));
            if (exp_seq[i] != 4'b0000) chk("rel_ascii", 32'(ascii_code), 32'h20);
        end
        step();
        chk("idle_ready", 32'(u_if.char_ready), 1);

        load(8'h31); load(8'h32); load(8'h33); load(8'h34);
        repeat (2) step();
        wait_digit(0, 8'h34, "l4_d0");
        wait_digit(1, 8'h33, "l4_d1");
        wait_digit(2, 8'h32, "l4_d2");
        wait_digit(3, 8'h31, "l4_d3");

        step();
        load(8'h35);
        repeat (2) step();
        wait_digit(0, 8'h35, "l5_d0");
        wait_digit(1, 8'h34, "l5_d1");
        wait_digit(2, 8'h33, "l5_d2");
        wait_digit(3, 8'h32, "l5_d3");

        step();
        load(8'h41); load(8'h61); load(8'h39); load(8'h3A);
        repeat (2) step();
        wait_digit(0, 8'h20, "flt_3A");
        wait_digit(1, 8'h39, "flt_39");
        wait_digit(2, hx,    "flt_61");
        wait_digit(3, hx,    "flt_41");

        step();
        u_if.clear      = 1'b1;
        u_if.char_valid = 1'b1;
        u_if.char_data  = 8'h37;
        #1 chk("clr_ready", 32'(u_if.char_ready), 0);
        step();
        u_if.clear      = 1'b0;
        u_if.char_valid = 1'b0;
        repeat (2) step();
        for (int d = 0; d < N; d++) wait_digit(d, 8'h20, "clr_blank");

        step();
        load(8'h35); load(8'h36); load(8'h37);
        repeat (2) step();
        wait_digit(2, 8'h35, "pre_rst_d2");
        #2 rst_n = 1'b0;
        #1;
        chk("async_digit_en", 32'(digit_en), 0);
        chk("async_ascii", 32'(ascii_code), 32'h20);
        chk("async_scan_idx", 32'(scan_idx), 3);
        chk("async_ready", 32'(u_if.char_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel2_guard", 32'(digit_en), 0);
        @(negedge clk);
        chk("rel2_first", 32'(digit_en), 32'b0001);
        chk("rel2_ascii", 32'(ascii_code), 32'h20);
        wait_digit(2, 8'h20, "rel2_d2_blank");

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
